pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Elastic pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
//   It is the receiving end of the stage-to-stage data path:
//   - accepts a 32-bit word from the upstream stage;
//   - returns registered backpressure (in_ready) upstream;
//   - presents the word to the downstream stage one cycle later.
//   It sits between MIPS pipeline stages where the downstream stage can stall.
//   It also supports a synchronous flush for branch/exception squash.
// PARAMETERS
//   WIDTH  32  data word width in bits
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   flush      in   1      squash both entries (synchronous)
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      block can accept a word this cycle (registered)
//   in_data    in   WIDTH  upstream word
//   out_valid  out  1      out_data valid
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  word presented downstream (driven from main register)
//   occupancy  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Storage: main register (main_q/main_v) and skid register (skid_q/skid_v).
//   - Output mapping: out_valid = main_v; out_data = main_q; in_ready = ~skid_v.
//     All are direct register outputs; there is no combinational in->out path.
//   - Occupancy: occupancy = main_v + skid_v.
//   - Reset (rst=1):
//     - main_v = skid_v = 0; main_q = skid_q = 0;
//     - next cycle: out_valid=0, in_ready=1, occupancy=0, out_data=0.
//   - States, decoded from {skid_v, main_v}:
//     EMPTY=00, ONE=01, FULL=11. The encoding 10 is illegal and never reached.
//   - Transitions:
//     - EMPTY:
//       - in_fire -> ONE; main_q <= in_data.
//     - ONE:
//       - in_fire & out_fire -> ONE; main_q <= in_data.
//       - in_fire & ~out_fire -> FULL; skid_q <= in_data.
//       - ~in_fire & out_fire -> EMPTY.
//       - otherwise hold.
//     - FULL (in_ready=0, so in_fire cannot occur):
//       - out_fire -> ONE; main_q <= skid_q.
//       - otherwise hold.
//   - Latency and throughput:
//     - A word accepted in cycle N is visible on out_data in cycle N+1 at the earliest.
//     - Sustained throughput is 1 word/cycle while out_ready=1.
//   - Ordering: strict FIFO. Words are never dropped, duplicated or reordered.
//   - Data stability: while out_valid=1 and out_ready=0, out_data must hold stable.
//   - Simultaneous accept and drain: in_fire and out_fire in the same cycle are legal.
//     In ONE, occupancy stays 1.
//   - Backpressure: in_ready deasserts only in the cycle after the skid register fills.
//     The skid register absorbs the one word accepted while the stall propagates.
//   - flush=1:
//     - Priority over in_fire and out_fire.
//     - Next cycle: main_v = skid_v = 0, giving EMPTY; data registers are unchanged.
//     - A word offered in the flush cycle is discarded, even if in_ready=1.
//   - rst has priority over flush; rst mid-transfer discards all held words.
//   - Upstream contract: holds in_data stable while in_valid=1 and in_ready=0.
//     The block does not check this.
// TESTING
//   1. Reset: assert rst 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
//   2. Streaming: out_ready=1; send 0x1,0x2,0x3 on consecutive cycles
//      -> out_data 0x1,0x2,0x3 one cycle later each; occupancy stays <=1.
//   3. Stall fill:
//      - out_ready=0; send 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held.
//      - Offer 0xC while in_ready=0 -> not accepted.
//      - Raise out_ready -> 0xA, 0xB, 0xC delivered in order.
//   4. Simultaneous: in ONE with main=0x5, in_fire(0x6) + out_fire together
//      -> next cycle out_data=0x6, occupancy=1.
//   5. Flush: in FULL (0x7, 0x8), assert flush with in_valid=1, in_data=0x9
//      -> next cycle occupancy=0, out_valid=0, in_ready=1; 0x9 never appears.
//   6. Random: random in_valid/out_ready for 10k cycles against a queue model
//      -> no loss, no duplication, in order; occupancy always <=2.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data, downstream valid/ready/data,
// squash control and occupancy status.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a one-entry skid buffer. All outputs come straight from
// registers, so upstream ready never depends combinationally on downstream ready.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    pipe_skid_reg_if.slave bus
);

    // Encoding is {skid_v, main_v}, so each valid flag is a bit of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_v;
    logic             skid_v;
    logic             in_fire;
    logic             out_fire;

    assign main_v   = state[0];
    assign skid_v   = state[1];
    assign in_fire  = bus.in_valid & ~skid_v;
    assign out_fire = main_v & bus.out_ready;

    assign bus.out_valid = main_v;
    assign bus.out_data  = main_q;
    assign bus.in_ready  = ~skid_v;
    assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            // Squash drops the valid flags only; stale data stays in the registers.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= bus.in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= bus.in_data;
                    end else if (in_fire) begin
                        state  <= FULL;
                        skid_q <= bus.in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomized run against a
// queue-based model of a two-entry FIFO stage.
module tb_pipe_skid_reg;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] model_q[$];

    pipe_skid_reg_if #(.WIDTH(32)) bus ();

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: applies inputs, advances one clock, updates the model.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit acc;
        bit pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        acc = v && (model_q.size() < 2);
        pop = r && (model_q.size() > 0);
        @(posedge clk);
        if (rst || f) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        model_q.delete();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data); end
    endtask

    task automatic test_streaming();
        logic [31:0] words[3] = '{32'h1, 32'h2, 32'h3};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, words[i], 1'b1, 1'b0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== words[i]) begin
                errors++; $display("[TB] FAIL stream_data%0d: got v=%0b %h expected v=1 %h", i, bus.out_valid, bus.out_data, words[i]);
            end
            checks++; if (bus.occupancy > 2'd1) begin errors++; $display("[TB] FAIL stream_occ%0d: got %0d expected <=1", i, bus.occupancy); end
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            errors++; $display("[TB] FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_stall_fill();
        drive_cycle(1'b1, 32'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hB, 1'b0, 1'b0);
        checks++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
            errors++; $display("[TB] FAIL stall_full: got occ=%0d rdy=%0b %h expected occ=2 rdy=0 a", bus.occupancy, bus.in_ready, bus.out_data);
        end
        drive_cycle(1'b1, 32'hC, 1'b0, 1'b0);
        checks++; if (bus.occupancy !== 2'd2 || bus.out_data !== 32'hA) begin
            errors++; $display("[TB] FAIL stall_hold: got occ=%0d %h expected occ=2 a", bus.occupancy, bus.out_data);
        end
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0);
        checks++; if (bus.out_data !== 32'hB || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_second: got %h occ=%0d rdy=%0b expected b occ=1 rdy=1", bus.out_data, bus.occupancy, bus.in_ready);
        end
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0);
        checks++; if (bus.out_data !== 32'hC || bus.occupancy !== 2'd1) begin
            errors++; $display("[TB] FAIL stall_third: got %h occ=%0d expected c occ=1", bus.out_data, bus.occupancy);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            errors++; $display("[TB] FAIL stall_empty: got v=%0b occ=%0d expected v=0 occ=0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 32'h5, 1'b0, 1'b0);
        checks++; if (bus.out_data !== 32'h5 || bus.occupancy !== 2'd1) begin
            errors++; $display("[TB] FAIL simul_load: got %h occ=%0d expected 5 occ=1", bus.out_data, bus.occupancy);
        end
        drive_cycle(1'b1, 32'h6, 1'b1, 1'b0);
        checks++; if (bus.out_data !== 32'h6 || bus.occupancy !== 2'd1 || bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL simul_swap: got %h occ=%0d v=%0b expected 6 occ=1 v=1", bus.out_data, bus.occupancy, bus.out_valid);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h7, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h8, 1'b0, 1'b0);
        checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("[TB] FAIL flush_prefill: got occ=%0d expected 2", bus.occupancy); end
        drive_cycle(1'b1, 32'h9, 1'b1, 1'b1);
        checks++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_empty: got occ=%0d v=%0b rdy=%0b expected occ=0 v=0 rdy=1", bus.occupancy, bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.out_data !== 32'h7) begin errors++; $display("[TB] FAIL flush_data_kept: got %h expected 7", bus.out_data); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data === 32'h9) begin
            errors++; $display("[TB] FAIL flush_discard: got v=%0b %h expected v=0 and never 9", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] d;
        logic        pending;
        int          sz;
        pending = 1'b0;
        d = 32'h0;
        for (int i = 0; i < 10000; i++) begin
            sz = model_q.size();
            checks++; if (bus.occupancy !== sz[1:0] || sz > 2) begin
                errors++; $display("[TB] FAIL rand_occ@%0d: got %0d expected %0d", i, bus.occupancy, sz);
            end
            checks++; if (bus.out_valid !== (sz > 0) || bus.in_ready !== (sz < 2)) begin
                errors++; $display("[TB] FAIL rand_flags@%0d: got v=%0b rdy=%0b expected v=%0b rdy=%0b", i, bus.out_valid, bus.in_ready, sz > 0, sz < 2);
            end
            if (sz > 0) begin
                checks++; if (bus.out_data !== model_q[0]) begin
                    errors++; $display("[TB] FAIL rand_data@%0d: got %h expected %h", i, bus.out_data, model_q[0]);
                end
            end
            // A stalled offer stays identical until taken.
            if (!pending) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end else begin
                v = 1'b1;
            end
            pending = v && (sz >= 2);
            drive_cycle(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
            if (bus.flush) pending = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_simultaneous();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
